hera_boot_loader: RTL and testbench
===================================

Name: hera_boot_loader

Overview:
- Serial program loader upstream of the HERA core's instruction ROM.
- Receives 8N1 UART frames on the COM port and assembles them into 16-bit instruction words.
- Writes the words into program memory through a write port, from address 0 upward.
- Holds the CPU in a frozen state from the first header byte until the load completes, so the core restarts cleanly from address 0.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal minimum 8.
- ADDR_W, 10, program memory address width; matches the 10-bit npc.
- TIMEOUT_CYC, 5000000, idle clocks allowed between bytes inside a packet before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx  in  1  UART receive line; idle high
- tx  out  1  UART transmit line (echo feature only)
- prog_we  out  1  one-cycle program memory write strobe
- prog_addr  out  ADDR_W  write address
- prog_data  out  16  instruction word
- cpu_hold  out  1  freezes the CPU while high
- busy  out  1  packet in progress
- load_done  out  1  one-cycle pulse on a successful load
- load_err  out  1  one-cycle pulse on an aborted load
- err_code  out  2  last error: 0 none, 1 framing, 2 checksum, 3 length/timeout

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - All outputs 0, except tx=1 and cpu_hold=0.
  - Reset mid-packet discards the packet. No write may occur after rst falls.
- RX front end:
  - rx passes through a 2-flop synchronizer, reset value 1.
  - A falling edge starts a bit counter. The start bit is re-sampled at CLKS_PER_BIT/2; if it reads 1, the event is a glitch and the receiver returns to idle.
  - Data bits are sampled at the centre of each bit, LSB first.
  - Stop bit sampled 0 gives a framing error.
  - A completed byte produces an internal one-cycle byte_valid.
- Packet format, bytes in order:
  - 0xA5 header.
  - LEN_HI, LEN_LO: word count N.
  - N words, high byte first.
  - CSUM: XOR of LEN_HI, LEN_LO and all data bytes.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, ERR.
  - IDLE: a byte equal to 0xA5 moves to LEN_HI, sets busy=1 and cpu_hold=1. Any other byte is ignored.
  - LEN_HI → LEN_LO.
  - LEN_LO:
    - N > 2^ADDR_W gives error 3.
    - N = 0 goes directly to CSUM.
    - Otherwise go to DATA_HI. The word counter is cleared to 0.
  - DATA_HI latches the high byte → DATA_LO.
  - DATA_LO:
    - prog_data={hi,lo}; prog_addr=counter; prog_we=1 in the cycle after byte_valid.
    - Counter increments.
    - When counter==N, go to CSUM; otherwise go to DATA_HI.
    - Latency from the stop-bit sample to prog_we is exactly 1 clock.
  - CSUM:
    - Match: load_done pulse, err_code=0, go to IDLE. busy and cpu_hold drop in the same cycle as load_done.
    - Mismatch: error 2.
  - ERR (1 cycle): load_err pulse, err_code latched, busy=0 → IDLE. cpu_hold remains 1 until the next successful load, so a partial image never runs.
- Timeout: within LEN_HI..CSUM, the idle-clock counter resets on each byte_valid. Reaching TIMEOUT_CYC gives error 3.
- A framing error in any non-IDLE state gives error 1. In IDLE it is silently dropped.
- prog_addr stays at the last written value between writes. N = 2^ADDR_W writes addresses 0..2^ADDR_W-1 with no wrap beyond.
- Words already written before an error are not rolled back.

Optional Feature:
- HERA_LOADER_ECHO_EN defined:
  - An 8N1 transmitter at CLKS_PER_BIT echoes every received byte on tx, starting the cycle after byte_valid.
  - A new echo request arriving while the transmitter is busy is dropped.
- Undefined: no transmitter logic; tx tied 1.

Test Plan:
- Reset → send A5 00 02 12 34 AB CD CSUM=0x02^0x12^0x34^0xAB^0xCD=0x42 → prog_we at addr 0 data 0x1234, then addr 1 data 0xABCD; load_done one pulse; cpu_hold 1 from header to done, then 0.
- Same packet with CSUM=0x43 → both writes occur, load_err pulse, err_code=2, cpu_hold stays 1; a following good packet clears cpu_hold.
- Send 0x00 0x7F then A5 00 00 00 → garbage ignored, no prog_we, load_done pulse.
- Send A5 then stop the stream for TIMEOUT_CYC+1 clocks → load_err, err_code=3. Separately, LEN=0x0401 with ADDR_W=10 → err_code=3 immediately after LEN_LO.
- A byte with stop bit forced 0 mid-DATA gives err_code=1. Separately, a 0.25-bit low glitch in IDLE produces no byte. Separately, rst low during DATA_LO gives no further prog_we and all outputs at reset values.
- HERA_LOADER_ECHO_EN defined, send 0x5A → tx reproduces start, 0,1,0,1,1,0,1,0, stop at CLKS_PER_BIT spacing.

Source files
------------

// File: rtl/hera_boot_loader.sv
// Serial program loader: 8N1 UART packets -> 16-bit words written into the HERA instruction ROM.
// Define HERA_LOADER_ECHO_EN to add an 8N1 transmitter that echoes every received byte on tx.
module hera_boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned TIMEOUT_CYC  = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              tx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned WC_W  = ADDR_W + 1;
    localparam logic [7:0]  HDR   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM, S_ERR
    } state_t;

    // UART receiver: synchronizer, start-bit glitch filter, centre sampling
    logic             rx_s1, rx_s2, rx_d;
    logic             rx_act;
    logic [3:0]       rx_bit;
    logic [CNT_W-1:0] rx_cnt;
    logic [7:0]       rx_sh;
    logic             byte_valid, frame_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_d       <= 1'b1;
            rx_act     <= 1'b0;
            rx_bit     <= '0;
            rx_cnt     <= '0;
            rx_sh      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_d       <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (!rx_act) begin
                if (rx_d && !rx_s2) begin
                    rx_act <= 1'b1;
                    rx_bit <= '0;
                    rx_cnt <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == CNT_W'(HALF - 1)) begin
                    rx_cnt <= '0;
                    if (rx_s2) rx_act <= 1'b0;
                    else       rx_bit <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CNT_W'(1);
                end
            end else if (rx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd9) begin
                    rx_act <= 1'b0;
                    if (rx_s2) byte_valid <= 1'b1;
                    else       frame_err  <= 1'b1;
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
        end
    end

    // Packet parser
    state_t            state, state_nxt;
    logic [1:0]        err_sel;
    logic [7:0]        len_hi, hi_byte, csum;
    logic [WC_W-1:0]   n_words, wcnt;
    logic [TMR_W-1:0]  timer;
    logic [15:0]       len_full;
    logic              in_pkt, timeout, len_bad;

    assign in_pkt   = (state != S_IDLE) && (state != S_ERR);
    assign timeout  = (timer == TMR_W'(TIMEOUT_CYC));
    assign len_full = {len_hi, rx_sh};
    assign len_bad  = {16'd0, len_full} > (32'd1 << ADDR_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_sel   = 2'd0;
        if (in_pkt && frame_err) begin
            state_nxt = S_ERR;
            err_sel   = 2'd1;
        end else if (in_pkt && timeout && !byte_valid) begin
            state_nxt = S_ERR;
            err_sel   = 2'd3;
        end else if (byte_valid) begin
            case (state)
                S_IDLE:    if (rx_sh == HDR) state_nxt = S_LEN_HI;
                S_LEN_HI:  state_nxt = S_LEN_LO;
                S_LEN_LO: begin
                    if (len_bad) begin
                        state_nxt = S_ERR;
                        err_sel   = 2'd3;
                    end else if (len_full == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA_HI;
                    end
                end
                S_DATA_HI: state_nxt = S_DATA_LO;
                S_DATA_LO: state_nxt = (wcnt + WC_W'(1) == n_words) ? S_CSUM : S_DATA_HI;
                S_CSUM: begin
                    if (rx_sh == csum) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_ERR;
                        err_sel   = 2'd2;
                    end
                end
                default: ;
            endcase
        end
        if (state == S_ERR) state_nxt = S_IDLE;
    end

    logic              prog_we_nxt, cpu_hold_nxt, busy_nxt, load_done_nxt, load_err_nxt;
    logic [ADDR_W-1:0] prog_addr_nxt;
    logic [15:0]       prog_data_nxt;
    logic [1:0]        err_code_nxt;

    always_comb begin
        prog_we_nxt   = 1'b0;
        prog_addr_nxt = prog_addr;
        prog_data_nxt = prog_data;
        cpu_hold_nxt  = cpu_hold;
        busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_ERR);
        load_done_nxt = 1'b0;
        load_err_nxt  = (state_nxt == S_ERR);
        err_code_nxt  = err_code;
        if (state == S_IDLE && state_nxt == S_LEN_HI) cpu_hold_nxt = 1'b1;
        if (state == S_DATA_LO && byte_valid) begin
            prog_we_nxt   = 1'b1;
            prog_addr_nxt = wcnt[ADDR_W-1:0];
            prog_data_nxt = {hi_byte, rx_sh};
        end
        if (state == S_CSUM && state_nxt == S_IDLE) begin
            load_done_nxt = 1'b1;
            cpu_hold_nxt  = 1'b0;
            err_code_nxt  = 2'd0;
        end
        // cpu_hold deliberately survives an error so a partial image never runs
        if (state_nxt == S_ERR) err_code_nxt = err_sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            prog_we   <= prog_we_nxt;
            prog_addr <= prog_addr_nxt;
            prog_data <= prog_data_nxt;
            cpu_hold  <= cpu_hold_nxt;
            busy      <= busy_nxt;
            load_done <= load_done_nxt;
            load_err  <= load_err_nxt;
            err_code  <= err_code_nxt;
        end
    end

    // Length, word counter, running checksum and inter-byte timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_hi  <= '0;
            hi_byte <= '0;
            csum    <= '0;
            n_words <= '0;
            wcnt    <= '0;
            timer   <= '0;
        end else begin
            if (!in_pkt || byte_valid) timer <= '0;
            else if (!timeout)         timer <= timer + TMR_W'(1);
            if (byte_valid) begin
                case (state)
                    S_LEN_HI: begin
                        len_hi <= rx_sh;
                        csum   <= rx_sh;
                    end
                    S_LEN_LO: begin
                        n_words <= WC_W'(len_full);
                        wcnt    <= '0;
                        csum    <= csum ^ rx_sh;
                    end
                    S_DATA_HI: begin
                        hi_byte <= rx_sh;
                        csum    <= csum ^ rx_sh;
                    end
                    S_DATA_LO: begin
                        wcnt <= wcnt + WC_W'(1);
                        csum <= csum ^ rx_sh;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef HERA_LOADER_ECHO_EN
    // Echo transmitter; requests arriving while busy are dropped
    logic             tx_busy;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_left;
    logic [8:0]       tx_sh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_cnt  <= '0;
            tx_left <= '0;
            tx_sh   <= '1;
        end else if (!tx_busy) begin
            if (byte_valid) begin
                tx      <= 1'b0;
                tx_sh   <= {1'b1, rx_sh};
                tx_left <= 4'd9;
                tx_cnt  <= '0;
                tx_busy <= 1'b1;
            end
        end else if (tx_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            tx_cnt <= '0;
            if (tx_left == 4'd0) begin
                tx_busy <= 1'b0;
            end else begin
                tx      <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[8:1]};
                tx_left <= tx_left - 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
        end
    end
`else
    assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_hera_boot_loader.sv
// Scoreboard bench for hera_boot_loader: directed UART packets, queued expected writes and load events.
`timescale 1ns/1ps
module tb_hera_boot_loader;
    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 10;
    localparam int unsigned TMO = 2000;
    localparam logic [9:0]  ECHO_FRAME = {1'b1, 8'h5A, 1'b0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          tx, prog_we, cpu_hold, busy, load_done, load_err;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic [1:0]    err_code;

    always #5 clk = ~clk;

    hera_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
        .load_err(load_err), .err_code(err_code)
    );

    typedef struct packed { logic [AW-1:0] addr; logic [15:0] data; } wr_t;
    typedef struct packed { logic done; logic [1:0] code; logic hold; } ev_t;
    typedef logic [7:0] bq_t[$];

    wr_t wq[$];
    ev_t eq[$];
    bq_t pk;
    int  checks = 0;
    int  failures = 0;
    int  waited;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic push_ev(input logic done, input logic [1:0] code, input logic hold);
        ev_t e;
        e.done = done;
        e.code = code;
        e.hold = hold;
        eq.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT writes or reports a load outcome
    task automatic monitor();
        wr_t w;
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prog_we) begin
                    chk("write_expected", 32'(wq.size() != 0), 32'd1);
                    if (wq.size() != 0) begin
                        w = wq.pop_front();
                        chk("write_addr_data", 32'({prog_addr, prog_data}), 32'({w.addr, w.data}));
                    end
                end
                if (load_done || load_err) begin
                    chk("event_expected", 32'(eq.size() != 0), 32'd1);
                    if (eq.size() != 0) begin
                        e = eq.pop_front();
                        chk("load_event", 32'({load_done, load_err, err_code, cpu_hold, busy}),
                            32'({e.done, ~e.done, e.code, e.hold, 1'b0}));
                    end
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
    endtask

    task automatic send_pkt(input bq_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic drain(input string nm, input int budget, output int n);
        n = 0;
        while ((wq.size() != 0 || eq.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(wq.size() + eq.size()), 32'd0);
    endtask

    task automatic good_pkt(input string nm);
        push_wr(10'd0, 16'h1234);
        push_wr(10'd1, 16'hABCD);
        push_ev(1'b1, 2'd0, 1'b0);
        pk = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_pkt(pk);
        drain(nm, 200, waited);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_write_port", 32'({prog_we, prog_addr, prog_data}), 32'd0);
        chk("reset_ctrl", 32'({cpu_hold, busy, load_done, load_err, err_code}), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

`ifdef HERA_LOADER_ECHO_EN
        fork
            send_byte(8'h5A);
            begin
                waited = 0;
                while (tx !== 1'b0 && waited < 20 * CPB) begin
                    @(negedge clk);
                    waited++;
                end
                chk("echo_start_seen", 32'(tx === 1'b0), 32'd1);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    chk("echo_bit", 32'(tx), 32'(ECHO_FRAME[i]));
                    if (i < 9) repeat (CPB) @(negedge clk);
                end
            end
        join
        repeat (2 * CPB) @(negedge clk);
`endif

        // Two-word load with cpu_hold tracking
        push_wr(10'd0, 16'h1234);
        push_wr(10'd1, 16'hABCD);
        push_ev(1'b1, 2'd0, 1'b0);
        send_byte(8'hA5);
        chk("hold_busy_after_header", 32'({cpu_hold, busy}), 32'd3);
        pk = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
        send_pkt(pk);
        drain("good_load", 200, waited);
        chk("hold_released", 32'({cpu_hold, busy}), 32'd0);

        // Bad checksum: words still written, hold kept until next good load
        push_wr(10'd0, 16'h1234);
        push_wr(10'd1, 16'hABCD);
        push_ev(1'b0, 2'd2, 1'b1);
        pk = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
        send_pkt(pk);
        drain("csum_error", 200, waited);
        chk("hold_after_csum_err", 32'({cpu_hold, err_code}), 32'({1'b1, 2'd2}));
        good_pkt("reload_clears_hold");

        // Garbage before header, then empty packet
        push_ev(1'b1, 2'd0, 1'b0);
        pk = '{8'h00, 8'h7F, 8'hA5, 8'h00, 8'h00, 8'h00};
        send_pkt(pk);
        drain("empty_packet", 200, waited);

        // Inter-byte timeout after header
        push_ev(1'b0, 2'd3, 1'b1);
        send_byte(8'hA5);
        drain("timeout_error", TMO + 400, waited);
        chk("timeout_not_early", 32'(waited >= int'(TMO - 2 * CPB)), 32'd1);

        // Length one past the address space aborts right after LEN_LO
        push_ev(1'b0, 2'd3, 1'b1);
        pk = '{8'hA5, 8'h04, 8'h01};
        send_pkt(pk);
        drain("len_too_long", 20, waited);

        // Length exactly 2^ADDR_W is accepted; abandon it through the timeout
        push_ev(1'b0, 2'd3, 1'b1);
        pk = '{8'hA5, 8'h04, 8'h00};
        send_pkt(pk);
        repeat (100) @(negedge clk);
        chk("len_max_accepted", 32'({eq.size() == 1, busy}), 32'd3);
        drain("len_max_timeout", TMO + 400, waited);

        // Framing error mid-data
        push_wr(10'd0, 16'h1234);
        push_ev(1'b0, 2'd1, 1'b1);
        pk = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        send_pkt(pk);
        send_byte(8'hAB, 1'b0);
        drain("frame_error", 200, waited);

        // Framing error in IDLE is dropped silently
        send_byte(8'h55, 1'b0);
        repeat (CPB) @(negedge clk);
        chk("idle_frame_dropped", 32'({busy, err_code, eq.size() == 0}), 32'({1'b0, 2'd1, 1'b1}));

        // Quarter-bit glitch immediately followed by a real packet
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        repeat (CPB - CPB / 4) @(negedge clk);
        push_ev(1'b1, 2'd0, 1'b0);
        pk = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_pkt(pk);
        drain("glitch_rejected", 200, waited);

        // Reset while waiting for the low byte of word 1
        push_wr(10'd0, 16'h1234);
        pk = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
        send_pkt(pk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = (i == 1) ? 1'b0 : 1'b1;
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        chk("midpkt_reset_tx", 32'(tx), 32'd1);
        chk("midpkt_reset_write_port", 32'({prog_we, prog_addr, prog_data}), 32'd0);
        chk("midpkt_reset_ctrl", 32'({cpu_hold, busy, load_done, load_err, err_code}), 32'd0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("no_write_after_reset", 32'({wq.size() == 0, busy, cpu_hold}), 32'd4);
        good_pkt("load_after_reset");

`ifndef HERA_LOADER_ECHO_EN
        chk("tx_idle", 32'(tx), 32'd1);
`endif
        chk("queues_empty", 32'(wq.size() + eq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
